// File: rtl/enemy_sprite_renderer.sv
// Rasterises a snapshot of every enemy plane into one VGA pixel write per cycle.
// Drawing paints with the plane's colour; erasing paints the same footprint with colour 000.
module enemy_sprite_renderer #(
  parameter int N_PLANES = 10,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [8*N_PLANES-1:0]   enemy_x,
  input  logic [8*N_PLANES-1:0]   enemy_y,
  input  logic [3*N_PLANES-1:0]   enemy_vis,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    done
);

  localparam int PIX = SPRITE_W * SPRITE_H;
  localparam int K_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int P_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t                        state;
  logic [N_PLANES-1:0][7:0]      x_s, y_s;
  logic [N_PLANES-1:0][2:0]      vis_s;
  logic [1:0]                    op_s;
  logic [P_W-1:0]                p;
  logic [K_W-1:0]                k;

  logic [7:0] cur_x, cur_y;
  logic [2:0] cur_vis;
  logic [8:0] col9, row9, sx, sy;
  logic       plane_on, last_pix, last_plane;

  assign cur_x      = x_s[p];
  assign cur_y      = y_s[p];
  assign cur_vis    = vis_s[p];
  assign col9       = 9'(int'(k) % SPRITE_W);
  assign row9       = 9'(int'(k) / SPRITE_W);
  // Nine-bit sums so sprites hanging off the right/bottom edge are clipped, not wrapped
  assign sx         = {1'b0, cur_x} + col9;
  assign sy         = {1'b0, cur_y} + row9;
  assign plane_on   = (|cur_vis) && !op_s[1];
  assign last_pix   = (k == K_W'(PIX - 1));
  assign last_plane = (p == P_W'(N_PLANES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_s        <= '0;
      y_s        <= '0;
      vis_s      <= '0;
      op_s       <= '0;
      p          <= '0;
      k          <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            x_s   <= enemy_x;
            y_s   <= enemy_y;
            vis_s <= enemy_vis;
            op_s  <= op;
            p     <= '0;
            k     <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          busy <= 1'b1;
          if (plane_on) begin
            vga_x      <= sx[7:0];
            vga_y      <= sy[6:0];
            vga_colour <= op_s[0] ? 3'b000 : cur_vis;
            vga_plot   <= (sx < 9'(SCREEN_W)) && (sy < 9'(SCREEN_H));
            k          <= last_pix ? '0 : k + 1'b1;
          end else begin
            vga_plot <= 1'b0;
          end
          // Skipped planes cost exactly one cycle; drawn planes move on after their last pixel
          if (!plane_on || last_pix) begin
            if (last_plane) state <= FLUSH;
            else            p     <= p + 1'b1;
          end
        end
        FLUSH: begin
          vga_plot <= 1'b0;
          busy     <= 1'b1;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Randomised and directed render passes checked against a per-cycle slot list
// derived from the sprite rules (one slot per pixel of a live plane, one per skipped plane).
module tb_enemy_sprite_renderer;

  localparam int N   = 10;
  localparam int SW  = 4;
  localparam int SH  = 4;
  localparam int SCW = 160;
  localparam int SCH = 120;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [1:0]       op;
  logic [8*N-1:0]   enemy_x, enemy_y;
  logic [3*N-1:0]   enemy_vis;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot, busy, done;

  enemy_sprite_renderer #(.N_PLANES(N), .SPRITE_W(SW), .SPRITE_H(SH),
                          .SCREEN_W(SCW), .SCREEN_H(SCH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_vis(enemy_vis),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct {bit pix; bit plot; int x; int y; int c;} slot_t;
  slot_t exp_q[$];

  function automatic void build(input logic [1:0] o, input logic [8*N-1:0] xs,
                                input logic [8*N-1:0] ys, input logic [3*N-1:0] vs);
    slot_t s;
    exp_q.delete();
    for (int pl = 0; pl < N; pl++) begin
      int x, y, v;
      x = int'(xs[8*pl +: 8]);
      y = int'(ys[8*pl +: 8]);
      v = int'(vs[3*pl +: 3]);
      if (v != 0 && o < 2) begin
        for (int r = 0; r < SH; r++)
          for (int c = 0; c < SW; c++) begin
            s.pix  = 1'b1;
            s.plot = (x + c < SCW) && (y + r < SCH);
            s.x    = (x + c) % 256;
            s.y    = (y + r) % 128;
            s.c    = (o == 2'd1) ? 0 : v;
            exp_q.push_back(s);
          end
      end else begin
        s = '{pix: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0};
        exp_q.push_back(s);
      end
    end
  endfunction

  // One full pass; with disturb set, inputs change and start re-pulses mid-pass.
  task automatic run_pass(input logic [1:0] o, input logic [8*N-1:0] xs,
                          input logic [8*N-1:0] ys, input logic [3*N-1:0] vs,
                          input bit disturb);
    @(negedge clk);
    op = o; enemy_x = xs; enemy_y = ys; enemy_vis = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    build(o, xs, ys, vs);
    chk("busy_at_accept", busy, 0);
    chk("plot_at_accept", vga_plot, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (disturb && i == 20) begin
        for (int pl = 0; pl < N; pl++) begin
          enemy_x[8*pl +: 8] = 8'($urandom_range(0, 255));
          enemy_y[8*pl +: 8] = 8'($urandom_range(0, 255));
        end
        enemy_vis = 30'($urandom);
        op        = 2'($urandom);
        start     = 1'b1;
      end
      if (disturb && i == 21) start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("plot[%0d]", i), vga_plot, exp_q[i].plot);
      if (exp_q[i].pix) begin
        chk($sformatf("x[%0d]", i), vga_x, exp_q[i].x);
        chk($sformatf("y[%0d]", i), vga_y, exp_q[i].y);
        chk($sformatf("colour[%0d]", i), vga_colour, exp_q[i].c);
      end
      chk($sformatf("busy[%0d]", i), busy, 1);
      chk($sformatf("done_early[%0d]", i), done, 0);
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_with_done", busy, 1);
    chk("plot_at_done", vga_plot, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_after", done, 0);
      chk("busy_after", busy, 0);
      chk("plot_after", vga_plot, 0);
    end
  endtask

  task automatic rand_planes(output logic [8*N-1:0] xs, output logic [8*N-1:0] ys,
                             output logic [3*N-1:0] vs);
    for (int pl = 0; pl < N; pl++) begin
      xs[8*pl +: 8] = 8'($urandom_range(0, 255));
      ys[8*pl +: 8] = 8'($urandom_range(0, 130));
      vs[3*pl +: 3] = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
    end
  endtask

  logic [8*N-1:0] xs, ys;
  logic [3*N-1:0] vs;

  initial begin
    reset = 1'b1; start = 1'b1; op = '0;
    enemy_x = '0; enemy_y = '0; enemy_vis = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Single plane at (10,20), draw then erase
    xs = '0; ys = '0; vs = '0;
    xs[7:0] = 8'd10; ys[7:0] = 8'd20; vs[2:0] = 3'b111;
    run_pass(2'b00, xs, ys, vs, 1'b0);
    run_pass(2'b01, xs, ys, vs, 1'b0);

    // All ten active in a row along y=0, disturbed mid-pass
    for (int pl = 0; pl < N; pl++) begin
      xs[8*pl +: 8] = 8'(pl * 16);
      ys[8*pl +: 8] = 8'd0;
      vs[3*pl +: 3] = 3'($urandom_range(1, 7));
    end
    run_pass(2'b00, xs, ys, vs, 1'b1);

    // Corner clipping
    xs = '0; ys = '0; vs = '0;
    xs[7:0] = 8'd158; ys[7:0] = 8'd118; vs[2:0] = 3'b101;
    run_pass(2'b00, xs, ys, vs, 1'b0);

    // No-op pass with every plane live
    rand_planes(xs, ys, vs);
    for (int pl = 0; pl < N; pl++) vs[3*pl +: 3] = 3'b011;
    run_pass(2'b10, xs, ys, vs, 1'b0);

    // Reset 50 cycles into a pass
    rand_planes(xs, ys, vs);
    for (int pl = 0; pl < N; pl++) vs[3*pl +: 3] = 3'b110;
    @(negedge clk);
    op = 2'b00; enemy_x = xs; enemy_y = ys; enemy_vis = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_plot", vga_plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_plot", vga_plot, 0);
      chk("post_rst_done", done, 0);
    end
    run_pass(2'b00, xs, ys, vs, 1'b0);

    // Random passes
    for (int t = 0; t < 6; t++) begin
      rand_planes(xs, ys, vs);
      run_pass(2'($urandom_range(0, 3)), xs, ys, vs, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
